// File: rtl/complex_mult_seq_if.sv
// complex_mult_seq_if: operand/result valid-ready bundle for the sequential complex multiplier.
interface complex_mult_seq_if #(parameter int W = 8);
  logic in_valid, in_ready, in_conj, out_valid, out_ready;
  logic signed [W-1:0] a_real, a_imag, b_real, b_imag;
  logic signed [2*W:0] z_real, z_imag;
  modport master(output in_valid, in_conj, a_real, a_imag, b_real, b_imag, out_ready,
                 input in_ready, out_valid, z_real, z_imag);
  modport slave(input in_valid, in_conj, a_real, a_imag, b_real, b_imag, out_ready,
                output in_ready, out_valid, z_real, z_imag);
endinterface

// File: rtl/complex_mult_seq.sv
// complex_mult_seq: a*b or a*conj(b) via three Gauss products on one shared multiplier.
module complex_mult_seq #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  complex_mult_seq_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic signed [W:0] ar, ai, br, bi, bi_in, m_a;
  logic signed [W+1:0] m_b;
  logic signed [2*W+2:0] k1, k2, prod, zr_full, zi_full;
  logic accept;
  assign bus.in_ready = rst_n && (state == IDLE || (state == DONE && bus.out_ready));
  assign bus.out_valid = state == DONE;
  assign accept = bus.in_valid && bus.in_ready;
  assign bi_in = {bus.b_imag[W-1], bus.b_imag};
  assign m_a = state == P1 ? br : state == P2 ? ar : ai;
  assign m_b = state == P1 ? {ar[W], ar} + {ai[W], ai} :
               state == P2 ? {bi[W], bi} - {br[W], br} : {br[W], br} + {bi[W], bi};
  assign prod = (2*W+3)'(m_a) * (2*W+3)'(m_b);
  // k3 is the P3 product itself and goes straight into z_real
  assign zr_full = k1 - prod;
  assign zi_full = k1 + k2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ar <= '0;
      ai <= '0;
      br <= '0;
      bi <= '0;
      k1 <= '0;
      k2 <= '0;
      bus.z_real <= '0;
      bus.z_imag <= '0;
    end else begin
      state <= state == IDLE ? (accept ? P1 : IDLE) :
               state == P1 ? P2 :
               state == P2 ? P3 :
               state == P3 ? DONE :
               state == DONE ? (accept ? P1 : bus.out_ready ? IDLE : DONE) : IDLE;
      if (accept) begin
        ar <= {bus.a_real[W-1], bus.a_real};
        ai <= {bus.a_imag[W-1], bus.a_imag};
        br <= {bus.b_real[W-1], bus.b_real};
        bi <= bus.in_conj ? -bi_in : bi_in;
      end
      if (state == P1) k1 <= prod;
      if (state == P2) k2 <= prod;
      if (state == P3) begin
        bus.z_real <= zr_full[2*W:0];
        bus.z_imag <= zi_full[2*W:0];
      end
    end
  end
endmodule
